// File: rtl/proc_trace_pkg.sv
// Shared types for the processor trace monitor: FSM state, trace entry layout, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package proc_trace_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_TS_W   = 16;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Trace entry at the default widths, ordered {ts, reg, data} from MSB down.
  // The monitor uses an identically ordered local struct built from its own parameters.
  typedef struct packed {
    logic [DEF_TS_W-1:0]   ts;
    logic [DEF_REG_W-1:0]  wreg;
    logic [DEF_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/proc_trace_monitor_if.sv
// Bundle of regfile tap, trace drain port and check request/result port.
// Latency: n/a (wires only).
// Backpressure: trc_valid/trc_ready and chk_valid/chk_ready handshakes.
// master = processor/bench side, slave = monitor side.
interface proc_trace_monitor_if
  import proc_trace_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int TS_W        = DEF_TS_W,
  parameter int ERR_W       = 8,
  parameter int TRACE_DEPTH = 16
);
  localparam int CNT_W = $clog2(TRACE_DEPTH) + 1;

  logic              wb_we;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;

  logic              trc_valid;
  logic              trc_ready;
  logic [TS_W-1:0]   trc_ts;
  logic [REG_W-1:0]  trc_reg;
  logic [DATA_W-1:0] trc_data;
  logic [CNT_W-1:0]  trc_count;
  logic              overflow;

  logic              chk_valid;
  logic              chk_ready;
  logic [REG_W-1:0]  chk_reg;
  logic [DATA_W-1:0] chk_expected;

  logic              res_valid;
  logic              res_pass;
  logic [DATA_W-1:0] res_actual;
  logic [ERR_W-1:0]  error_count;
  logic              done;
  logic [TS_W-1:0]   cycle_count;

  modport master (
    output wb_we, wb_reg, wb_data, trc_ready, chk_valid, chk_reg, chk_expected,
    input  trc_valid, trc_ts, trc_reg, trc_data, trc_count, overflow,
           chk_ready, res_valid, res_pass, res_actual, error_count, done, cycle_count
  );

  modport slave (
    input  wb_we, wb_reg, wb_data, trc_ready, chk_valid, chk_reg, chk_expected,
    output trc_valid, trc_ts, trc_reg, trc_data, trc_count, overflow,
           chk_ready, res_valid, res_pass, res_actual, error_count, done, cycle_count
  );

endinterface

// File: rtl/proc_trace_monitor_trace_fifo.sv
// First-word fall-through synchronous FIFO; head is visible the cycle after the first push.
// Latency: 1 cycle push-to-head; pop takes effect at the clock edge.
// Backpressure: push on full is dropped unless a pop occurs in the same cycle.
// Ports: clock/reset, push/din, pop/dout (zero when empty), empty, full, count.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push needs, so full+push+pop is lossless.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/proc_trace_monitor.sv
// Regfile write-port monitor: shadows writes and timestamps them into a trace FIFO for
// CYCLE_LIMIT cycles, then answers expected-value checks with a saturating error count.
// Latency: trace head 1 cycle after the write; check result 1 cycle after accept.
// Backpressure: writes dropped (overflow sticky) when trace full; checks stalled until done.
// Ports: clock, reset (async active-low), bus (tap, trace drain, check request/result).
module proc_trace_monitor
  import proc_trace_pkg::*;
#(
  parameter int CYCLE_LIMIT = 1000,
  parameter int TRACE_DEPTH = 16,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int TS_W        = DEF_TS_W,
  parameter int ERR_W       = 8
) (
  input logic                  clock,
  input logic                  reset,
  proc_trace_monitor_if.slave  bus
);
  localparam int NREG = 2 ** REG_W;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state, state_nxt;
  logic              capture, accept, fifo_full, fifo_empty;
  logic [TS_W-1:0]   cycle_count;
  logic [DATA_W-1:0] shadow [NREG];
  logic [DATA_W-1:0] shadow_rd;
  entry_t            push_ent, head_ent;
  logic              overflow, res_valid, res_pass;
  logic [DATA_W-1:0] res_actual;
  logic [ERR_W-1:0]  error_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      RUN: begin
        // r0 is hardwired zero in the processor, so its writes are not events.
        capture = bus.wb_we && (bus.wb_reg != '0);
        if (cycle_count == TS_W'(CYCLE_LIMIT - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  // Counts only in RUN, so it freezes at CYCLE_LIMIT on entering DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)             cycle_count <= '0;
    else if (state == RUN)  cycle_count <= cycle_count + TS_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else if (capture) begin
      shadow[bus.wb_reg] <= bus.wb_data;
    end
  end

  assign push_ent = '{ts: cycle_count, wreg: bus.wb_reg, data: bus.wb_data};

  trace_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (capture),
    .din   (push_ent),
    .pop   (bus.trc_ready),
    .dout  (head_ent),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (bus.trc_count)
  );

  // When full, trc_valid is high, so trc_ready alone means a pop happens.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                      overflow <= 1'b0;
    else if (capture && fifo_full && !bus.trc_ready) overflow <= 1'b1;
  end

  assign accept    = bus.chk_valid && (state == DONE);
  assign shadow_rd = shadow[bus.chk_reg];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_valid   <= 1'b0;
      res_pass    <= 1'b0;
      res_actual  <= '0;
      error_count <= '0;
    end else begin
      res_valid <= accept;
      if (accept) begin
        res_actual <= shadow_rd;
        res_pass   <= (shadow_rd == bus.chk_expected);
        if ((shadow_rd != bus.chk_expected) && (error_count != '1))
          error_count <= error_count + ERR_W'(1);
      end
    end
  end

  assign bus.trc_valid   = !fifo_empty;
  assign bus.trc_ts      = head_ent.ts;
  assign bus.trc_reg     = head_ent.wreg;
  assign bus.trc_data    = head_ent.data;
  assign bus.overflow    = overflow;
  assign bus.chk_ready   = (state == DONE);
  assign bus.res_valid   = res_valid;
  assign bus.res_pass    = res_pass;
  assign bus.res_actual  = res_actual;
  assign bus.error_count = error_count;
  assign bus.done        = (state == DONE);
  assign bus.cycle_count = cycle_count;

endmodule

// File: tb/tb_proc_trace_monitor.sv
// Directed bench for proc_trace_monitor: two instances (ERR_W=8 and ERR_W=1) share stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_proc_trace_monitor;
  import proc_trace_pkg::*;

  localparam int CL = 10;
  localparam int TD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        trc_ready = 1'b0;
  logic        chk_valid = 1'b0;
  logic [4:0]  chk_reg = '0;
  logic [31:0] chk_expected = '0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  proc_trace_monitor_if #(.DATA_W(32), .REG_W(5), .TS_W(16), .ERR_W(8), .TRACE_DEPTH(TD)) ifc1 ();
  proc_trace_monitor_if #(.DATA_W(32), .REG_W(5), .TS_W(16), .ERR_W(1), .TRACE_DEPTH(TD)) ifc2 ();

  assign ifc1.wb_we = wb_we;         assign ifc2.wb_we = wb_we;
  assign ifc1.wb_reg = wb_reg;       assign ifc2.wb_reg = wb_reg;
  assign ifc1.wb_data = wb_data;     assign ifc2.wb_data = wb_data;
  assign ifc1.trc_ready = trc_ready; assign ifc2.trc_ready = trc_ready;
  assign ifc1.chk_valid = chk_valid; assign ifc2.chk_valid = chk_valid;
  assign ifc1.chk_reg = chk_reg;     assign ifc2.chk_reg = chk_reg;
  assign ifc1.chk_expected = chk_expected;
  assign ifc2.chk_expected = chk_expected;

  proc_trace_monitor #(.CYCLE_LIMIT(CL), .TRACE_DEPTH(TD), .DATA_W(32), .REG_W(5),
                       .TS_W(16), .ERR_W(8)) dut1 (.clock(clock), .reset(reset), .bus(ifc1));
  proc_trace_monitor #(.CYCLE_LIMIT(CL), .TRACE_DEPTH(TD), .DATA_W(32), .REG_W(5),
                       .TS_W(16), .ERR_W(1)) dut2 (.clock(clock), .reset(reset), .bus(ifc2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic trace_entry_t mk(input int ts, input int r, input logic [31:0] d);
    trace_entry_t e;
    e.ts   = 16'(ts);
    e.wreg = 5'(r);
    e.data = d;
    return e;
  endfunction

  task automatic chk_head(input string tag, input trace_entry_t e);
    check({tag, "_valid"}, ifc1.trc_valid, 1);
    check({tag, "_head"}, {ifc1.trc_ts, ifc1.trc_reg, ifc1.trc_data}, e);
  endtask

  task automatic wr(input int r, input logic [31:0] d);
    wb_we = 1'b1; wb_reg = 5'(r); wb_data = d;
    tick();
    wb_we = 1'b0; wb_reg = '0; wb_data = '0;
  endtask

  task automatic chk_req(input int r, input logic [31:0] e);
    chk_valid = 1'b1; chk_reg = 5'(r); chk_expected = e;
    tick();
  endtask

  task automatic restart();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  trace_entry_t drain_exp [4];

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_done", ifc1.done, 0);
    check("rst_trc_valid", ifc1.trc_valid, 0);
    check("rst_count", ifc1.trc_count, 0);
    check("rst_overflow", ifc1.overflow, 0);
    check("rst_err", ifc1.error_count, 0);
    check("rst_cycle", ifc1.cycle_count, 0);
    check("rst_res_valid", ifc1.res_valid, 0);
    check("rst_chk_ready", ifc1.chk_ready, 0);
    check("rst_head", {ifc1.trc_ts, ifc1.trc_reg, ifc1.trc_data}, 0);

    // Run 1: basic capture, r0 ignored, window edge, checks
    reset = 1'b1;
    tick(); tick();                 // cycle_count 2
    wr(1, 32'd5);                   // ts 2
    wr(2, 32'd7);                   // ts 3
    wr(0, 32'hDEAD);                // ignored
    check("r1_count", ifc1.trc_count, 2);
    chk_head("r1_e0", mk(2, 1, 32'd5));
    check("r1_cycle", ifc1.cycle_count, 5);
    check("r1_chk_ready_run", ifc1.chk_ready, 0);
    chk_valid = 1'b1; chk_reg = 5'd1; chk_expected = 32'd5;
    trc_ready = 1'b1;
    tick();                         // cycle 6, one pop, check stalled
    check("r1_stall_res", ifc1.res_valid, 0);
    chk_head("r1_e1", mk(3, 2, 32'd7));
    check("r1_count1", ifc1.trc_count, 1);
    chk_valid = 1'b0;
    tick();                         // cycle 7
    trc_ready = 1'b0;
    check("r1_empty", ifc1.trc_valid, 0);
    tick(); tick();                 // cycle 9
    check("r1_done_lo", ifc1.done, 0);
    wr(3, 32'h99);                  // ts 9: last captured
    check("r1_done_hi", ifc1.done, 1);
    check("r1_cycle_lim", ifc1.cycle_count, CL);
    wr(4, 32'h77);                  // after window: ignored
    check("r1_cycle_hold", ifc1.cycle_count, CL);
    check("r1_count_last", ifc1.trc_count, 1);
    chk_head("r1_last", mk(9, 3, 32'h99));
    check("r1_chk_ready_done", ifc1.chk_ready, 1);

    chk_req(1, 32'd5);
    check("c0_valid", ifc1.res_valid, 1);
    check("c0_pass", ifc1.res_pass, 1);
    check("c0_actual", ifc1.res_actual, 5);
    check("c0_err", ifc1.error_count, 0);
    chk_req(2, 32'd8);
    check("c1_valid", ifc1.res_valid, 1);
    check("c1_pass", ifc1.res_pass, 0);
    check("c1_actual", ifc1.res_actual, 7);
    check("c1_err", ifc1.error_count, 1);
    chk_req(4, 32'h77);
    check("c2_valid", ifc1.res_valid, 1);
    check("c2_pass", ifc1.res_pass, 0);
    check("c2_actual", ifc1.res_actual, 0);
    check("c2_err", ifc1.error_count, 2);
    check("c2_err_sat", ifc2.error_count, 1);
    chk_req(0, 32'd0);
    check("c3_pass", ifc1.res_pass, 1);
    check("c3_actual", ifc1.res_actual, 0);
    check("c3_err", ifc1.error_count, 2);
    chk_valid = 1'b0;
    tick();
    check("c_idle", ifc1.res_valid, 0);

    // Run 2: overflow and push+pop on full
    restart();
    for (int i = 1; i <= 6; i++) wr(i, 32'h10 + 32'(i));   // ts 0..5
    check("r2_count", ifc1.trc_count, TD);
    check("r2_overflow", ifc1.overflow, 1);
    chk_head("r2_head", mk(0, 1, 32'h11));
    wb_we = 1'b1; wb_reg = 5'd7; wb_data = 32'h17; trc_ready = 1'b1;
    tick();                                                  // ts 6
    wb_we = 1'b0; trc_ready = 1'b0;
    check("r2_pp_count", ifc1.trc_count, TD);
    check("r2_pp_overflow", ifc1.overflow, 1);
    drain_exp[0] = mk(1, 2, 32'h12);
    drain_exp[1] = mk(2, 3, 32'h13);
    drain_exp[2] = mk(3, 4, 32'h14);
    drain_exp[3] = mk(6, 7, 32'h17);
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("r2_drain%0d", i), drain_exp[i]);
      trc_ready = 1'b1;
      tick();
      trc_ready = 1'b0;
    end
    check("r2_drained", ifc1.trc_count, 0);
    check("r2_done", ifc1.done, 1);

    // Run 3: push+pop on empty, then reset while a result is pending
    restart();
    trc_ready = 1'b1;
    wr(1, 32'h55);
    trc_ready = 1'b0;
    check("r3_pp_empty", ifc1.trc_count, 1);
    chk_head("r3_head", mk(0, 1, 32'h55));
    for (int i = 0; i < 9; i++) tick();
    check("r3_done", ifc1.done, 1);
    chk_req(1, 32'hBAD);
    chk_valid = 1'b0;
    check("r3_res_pending", ifc1.res_valid, 1);
    check("r3_err_pending", ifc1.error_count, 1);
    reset = 1'b0;
    #1;
    check("r3_rst_res", ifc1.res_valid, 0);
    check("r3_rst_err", ifc1.error_count, 0);
    check("r3_rst_count", ifc1.trc_count, 0);
    check("r3_rst_done", ifc1.done, 0);
    check("r3_rst_cycle", ifc1.cycle_count, 0);
    tick();
    check("r3_rst_res_hold", ifc1.res_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/proc_trace_monitor.md
Name: proc_trace_monitor

Overview:
- Synthesizable, parametrised successor to the processor bench's register checker.
- Sits beside the processor and taps the regfile write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) for a bounded run window of CYCLE_LIMIT cycles.
- Maintains a shadow register file and a timestamped write-trace FIFO.
- After the window closes, it answers expected-value check requests and keeps a running error count, so the check runs on-board as well as in simulation.

Parameters:
CYCLE_LIMIT, 1000, number of clock cycles captured after reset release
TRACE_DEPTH, 16, trace FIFO entries; power of two, >=2
DATA_W, 32, register data width
REG_W, 5, register index width; shadow holds 2**REG_W entries
TS_W, 16, timestamp/cycle counter width; must satisfy CYCLE_LIMIT < 2**TS_W
ERR_W, 8, error counter width

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
wb_we  in  1  regfile write enable tap
wb_reg  in  REG_W  regfile write index tap
wb_data  in  DATA_W  regfile write data tap
trc_valid  out  1  trace head entry available
trc_ready  in  1  consumer pops head when trc_valid&&trc_ready
trc_ts  out  TS_W  head entry cycle stamp
trc_reg  out  REG_W  head entry register index
trc_data  out  DATA_W  head entry data
trc_count  out  $clog2(TRACE_DEPTH)+1  current occupancy
overflow  out  1  sticky: a write event was dropped on full
chk_valid  in  1  check request
chk_ready  out  1  request accepted when chk_valid&&chk_ready
chk_reg  in  REG_W  register to check
chk_expected  in  DATA_W  expected value
res_valid  out  1  one-cycle pulse with result
res_pass  out  1  shadow == expected
res_actual  out  DATA_W  shadow value read
error_count  out  ERR_W  mismatches, saturating
done  out  1  run window closed
cycle_count  out  TS_W  cycles since reset release, stops at CYCLE_LIMIT

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; FSM in RUN; shadow entries 0; FIFO empty; overflow, error_count, cycle_count all 0.
- FSM states:
  - RUN -> DONE when cycle_count == CYCLE_LIMIT-1 at a rising edge.
  - DONE is terminal until reset.
  - No other states.
- RUN:
  - cycle_count increments every cycle.
  - Write event = wb_we && wb_reg != 0, sampled at each edge.
  - On an event, shadow[wb_reg] <= wb_data and {cycle_count, wb_reg, wb_data} is pushed to the FIFO.
  - Writes to r0 are ignored entirely; shadow[0] stays 0.
  - The last captured cycle is cycle_count == CYCLE_LIMIT-1.
- DONE:
  - done=1; cycle_count holds CYCLE_LIMIT.
  - Taps are ignored: no shadow update, no push.
- FIFO:
  - First-word fall-through; trc_valid = (count != 0); head fields are valid whenever trc_valid.
  - Pointers wrap modulo TRACE_DEPTH.
  - Push when full without a pop: entry dropped, overflow set, count unchanged.
  - Simultaneous push and pop when full: both occur, count unchanged, no overflow.
  - Simultaneous push and pop when empty: push stored, trc_valid next cycle.
  - Pops remain legal in DONE (drain after run).
- Check port:
  - chk_ready = done (0 during RUN; requests are stalled, not dropped).
  - On accept at edge N: res_valid=1 for the cycle after N, with res_actual = shadow[chk_reg] and res_pass = (res_actual == chk_expected).
  - Back-to-back accepts give one result per cycle.
  - On mismatch, error_count increments, saturating at 2**ERR_W-1.
  - Checking r0 returns actual 0.
- Reset asserted mid-run or mid-check: immediate return to reset state; pending result discarded.

Decomposition:
- Shared package (proc_trace_pkg):
  - trace entry struct {ts, reg, data}
  - FSM state enum {RUN, DONE}
  - default width constants DATA_W=32, REG_W=5
- One sub-module, trace_fifo: parametrised FFWT synchronous FIFO (WIDTH, DEPTH), exposing count and full/empty.
- Shadow file and FSM stay in the top.

Test Plan:
- Reset then r1<=5 at cycle 2 and r2<=7 at cycle 3 (CYCLE_LIMIT=10) -> trace holds {2,1,5} then {3,2,7}; done rises after cycle 9; check r1=5 gives res_pass=1 and actual 5.
- Write r0<=0xDEAD, then check r0 expecting 0 -> no trace entry; res_pass=1 with actual 0; error_count stays 0.
- TRACE_DEPTH=4, 6 writes with no pops -> trc_count=4, overflow=1, first 4 entries intact; next push/pop on the same cycle when full -> count stays 4, no data loss.
- Write at cycle CYCLE_LIMIT-1 vs CYCLE_LIMIT -> first captured, second ignored; chk_ready stays 0 until done.
- Three back-to-back checks (pass, fail, fail) in DONE -> three consecutive res_valid pulses; error_count=2; with ERR_W=1, it saturates at 1.
- Assert reset during a pending check -> res_valid=0, error_count=0, FIFO empty, done=0 immediately.
